sync_fifo_prog: RTL and testbench

- Single-clock, parametrised FIFO; the single-clock successor to the dual-clock FIFO.
- Used where producer and consumer share one clock.
- Adds over the first-generation FIFO:
  - non-power-of-two depth;
  - selectable standard or first-word-fall-through (FWFT) read mode;
  - runtime almost-full/almost-empty thresholds;
  - fill count;
  - sticky overflow/underflow error flags.

---
 rtl/sync_fifo_prog.sv | 164 ++++++++++++++++
 tb/tb_sync_fifo_prog.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
//
// Single-clock parametrised FIFO with arbitrary (non power-of-two) depth,
// selectable standard / first-word-fall-through read mode, runtime
// almost-full / almost-empty thresholds, a fill count and sticky
// overflow / underflow error flags.
//
// Parameters
//   DATA_WIDTH   word width in bits
//   DEPTH        number of entries, any integer >= 2
//   FWFT         0 = registered read (1-cycle latency), 1 = fall-through
//
// Ports
//   clk            rising-edge clock for all state
//   rst            synchronous active-low reset
//   wr_data/wr_en  write word and write request
//   full           FIFO holds DEPTH words
//   almost_full    count >= af_thresh
//   rd_en          read request (pop/acknowledge in FWFT mode)
//   rd_data        read word
//   rd_valid       rd_data is valid (registered strobe, or ~empty in FWFT)
//   empty          FIFO holds no words
//   almost_empty   count <= ae_thresh
//   count          current fill level, 0..DEPTH
//   af_thresh      almost-full threshold (quasi-static)
//   ae_thresh      almost-empty threshold (quasi-static)
//   clr_err        clears overflow and underflow
//   overflow       sticky: write attempted while full
//   underflow      sticky: read attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo_prog #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    parameter  int FWFT       = 0,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    // Storage and pointer state
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic                  wr_acc;
    logic                  rd_acc;

    // Pointers wrap explicitly at DEPTH-1 because DEPTH need not be a
    // power of two, so natural binary rollover cannot be relied on.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1))
            return '0;
        else
            return p + AW'(1);
    endfunction

    // Status flags are decoded from the registered count, so a write into
    // a full FIFO is refused even if a read is accepted the same cycle,
    // and likewise a read from an empty FIFO.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Memory array has no reset; only accepted writes outside reset land.
    always_ff @(posedge clk) begin
        if (rst && wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    // Pointer and fill-count bookkeeping. A simultaneous accepted read and
    // write leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= next_ptr(wr_ptr);
            if (rd_acc)
                rd_ptr <= next_ptr(rd_ptr);
            unique case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags: a new error in the same cycle as clr_err wins,
    // so an error is never silently lost by a clear that races it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full)
                overflow_q <= 1'b1;
            else if (clr_err)
                overflow_q <= 1'b0;

            if (rd_en && empty)
                underflow_q <= 1'b1;
            else if (clr_err)
                underflow_q <= 1'b0;
        end
    end

    // Read port: registered read with a one-cycle valid strobe, or a
    // combinational view of the head entry in fall-through mode.
    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc)
                        rd_data_q <= mem[rd_ptr];
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_fwft
            assign rd_data  = mem[rd_ptr];
            assign rd_valid = ~empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_prog
//
// Directed self-checking bench for sync_fifo_prog. Three instances share one
// clock and reset: a 16-deep standard-mode FIFO, a 5-deep standard-mode FIFO
// for odd-depth wrap, and a 16-deep fall-through FIFO.
// ---------------------------------------------------------------------------
module tb_sync_fifo_prog;

    logic clk = 1'b0;
    logic rst;
    logic clr_err;

    always #5 clk = ~clk;

    // 16-deep standard instance
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_wr_en, a_rd_en, a_full, a_afull, a_rd_valid, a_empty, a_aempty;
    logic       a_ovf, a_unf;
    logic [4:0] a_count, thr_af, thr_ae;

    // 5-deep standard instance
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_wr_en, b_rd_en, b_full, b_afull, b_rd_valid, b_empty, b_aempty;
    logic       b_ovf, b_unf;
    logic [2:0] b_count, b_af, b_ae;

    // 16-deep fall-through instance
    logic [7:0] f_wr_data, f_rd_data;
    logic       f_wr_en, f_rd_en, f_full, f_afull, f_rd_valid, f_empty, f_aempty;
    logic       f_ovf, f_unf;
    logic [4:0] f_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] q [$];

    sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) dut_a (
        .clk(clk), .rst(rst), .wr_data(a_wr_data), .wr_en(a_wr_en),
        .full(a_full), .almost_full(a_afull), .rd_en(a_rd_en),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .empty(a_empty),
        .almost_empty(a_aempty), .count(a_count), .af_thresh(thr_af),
        .ae_thresh(thr_ae), .clr_err(clr_err), .overflow(a_ovf),
        .underflow(a_unf));

    sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) dut_b (
        .clk(clk), .rst(rst), .wr_data(b_wr_data), .wr_en(b_wr_en),
        .full(b_full), .almost_full(b_afull), .rd_en(b_rd_en),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .empty(b_empty),
        .almost_empty(b_aempty), .count(b_count), .af_thresh(b_af),
        .ae_thresh(b_ae), .clr_err(clr_err), .overflow(b_ovf),
        .underflow(b_unf));

    sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr_data(f_wr_data), .wr_en(f_wr_en),
        .full(f_full), .almost_full(f_afull), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty),
        .almost_empty(f_aempty), .count(f_count), .af_thresh(thr_af),
        .ae_thresh(thr_ae), .clr_err(clr_err), .overflow(f_ovf),
        .underflow(f_unf));

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; clr_err = 1'b0;
        thr_af = 5'd12; thr_ae = 5'd3; b_af = 3'd4; b_ae = 3'd1;
        a_wr_en = 0; a_rd_en = 0; a_wr_data = 0;
        b_wr_en = 0; b_rd_en = 0; b_wr_data = 0;
        f_wr_en = 0; f_rd_en = 0; f_wr_data = 0;
        repeat (2) tick();
        total++; if (a_count !== 5'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", a_count); end
        total++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_empty_full got=%b%b want=10", a_empty, a_full); end
        total++; if (a_rd_valid !== 1'b0 || a_rd_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_rd got=%b/%h want=0/00", a_rd_valid, a_rd_data); end
        total++; if (a_aempty !== 1'b1 || a_afull !== 1'b0) begin bad++; $display("[TB] FAIL reset_almost got=%b%b want=10", a_aempty, a_afull); end
        total++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b%b want=00", a_ovf, a_unf); end
        total++; if (b_empty !== 1'b1 || f_empty !== 1'b1 || f_rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_others got=%b%b%b want=110", b_empty, f_empty, f_rd_valid); end
        rst = 1'b1;
        tick();
    endtask

    // Fill 0x00..0x0F, checking count and threshold flags at every level.
    task automatic test_fill_thresholds();
        for (int i = 0; i < 16; i++) begin
            a_wr_en = 1'b1; a_wr_data = 8'(i);
            tick();
            total++; if (a_count !== 5'(i + 1)) begin bad++; $display("[TB] FAIL fill_count got=%0d want=%0d", a_count, i + 1); end
            total++; if (a_aempty !== ((i + 1) <= 3)) begin bad++; $display("[TB] FAIL almost_empty count=%0d got=%b want=%b", i + 1, a_aempty, ((i + 1) <= 3)); end
            total++; if (a_afull !== ((i + 1) >= 12)) begin bad++; $display("[TB] FAIL almost_full count=%0d got=%b want=%b", i + 1, a_afull, ((i + 1) >= 12)); end
        end
        a_wr_en = 1'b0;
        total++; if (a_full !== 1'b1 || a_empty !== 1'b0) begin bad++; $display("[TB] FAIL fill_full got=%b%b want=10", a_full, a_empty); end
    endtask

    task automatic test_overflow();
        a_wr_en = 1'b1; a_wr_data = 8'hAA;
        tick();
        a_wr_en = 1'b0;
        total++; if (a_count !== 5'd16) begin bad++; $display("[TB] FAIL ovf_count got=%0d want=16", a_count); end
        total++; if (a_ovf !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=1", a_ovf); end
    endtask

    // Drain: 0x00 first also shows the rejected 0xAA did not land.
    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            a_rd_en = 1'b1;
            tick();
            total++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'(i)) begin bad++; $display("[TB] FAIL drain_data idx=%0d got=%b/%h want=1/%h", i, a_rd_valid, a_rd_data, 8'(i)); end
        end
        a_rd_en = 1'b0;
        total++; if (a_empty !== 1'b1 || a_count !== 5'd0) begin bad++; $display("[TB] FAIL drain_empty got=%b/%0d want=1/0", a_empty, a_count); end
        tick();
        total++; if (a_rd_valid !== 1'b0 || a_rd_data !== 8'h0F) begin bad++; $display("[TB] FAIL drain_hold got=%b/%h want=0/0f", a_rd_valid, a_rd_data); end
    endtask

    task automatic test_underflow();
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        total++; if (a_unf !== 1'b1) begin bad++; $display("[TB] FAIL unf_flag got=%b want=1", a_unf); end
        total++; if (a_rd_valid !== 1'b0 || a_count !== 5'd0) begin bad++; $display("[TB] FAIL unf_state got=%b/%0d want=0/0", a_rd_valid, a_count); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        total++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin bad++; $display("[TB] FAIL clr_both got=%b%b want=00", a_ovf, a_unf); end
        for (int i = 0; i < 5; i++) begin
            a_wr_en = 1'b1; a_wr_data = 8'(8'h10 + i);
            tick();
            q.push_back(8'(8'h10 + i));
        end
        for (int i = 0; i < 10; i++) begin
            a_wr_en = 1'b1; a_rd_en = 1'b1; a_wr_data = 8'(8'h15 + i);
            tick();
            exp = q.pop_front();
            q.push_back(8'(8'h15 + i));
            total++; if (a_rd_data !== exp || a_count !== 5'd5) begin bad++; $display("[TB] FAIL simul_rw idx=%0d got=%h/%0d want=%h/5", i, a_rd_data, a_count, exp); end
        end
        a_rd_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            a_wr_data = 8'(8'h1F + i);
            tick();
            q.push_back(8'(8'h1F + i));
        end
        total++; if (a_full !== 1'b1) begin bad++; $display("[TB] FAIL refill_full got=%b want=1", a_full); end
        // Read and write at full: read accepted, write refused.
        a_rd_en = 1'b1; a_wr_data = 8'h2A;
        tick();
        exp = q.pop_front();
        total++; if (a_rd_data !== exp || a_count !== 5'd15 || a_ovf !== 1'b1) begin bad++; $display("[TB] FAIL full_rw got=%h/%0d/%b want=%h/15/1", a_rd_data, a_count, a_ovf, exp); end
        a_rd_en = 1'b0; a_wr_data = 8'h2B;
        tick();
        q.push_back(8'h2B);
        a_wr_data = 8'h2C; clr_err = 1'b1;
        tick();
        a_wr_en = 1'b0;
        total++; if (a_ovf !== 1'b1 || a_count !== 5'd16) begin bad++; $display("[TB] FAIL set_beats_clr got=%b/%0d want=1/16", a_ovf, a_count); end
        tick();
        clr_err = 1'b0;
        total++; if (a_ovf !== 1'b0) begin bad++; $display("[TB] FAIL clr_alone got=%b want=0", a_ovf); end
        for (int i = 0; i < 16; i++) begin
            a_rd_en = 1'b1;
            tick();
            exp = q.pop_front();
            total++; if (a_rd_data !== exp) begin bad++; $display("[TB] FAIL final_drain idx=%0d got=%h want=%h", i, a_rd_data, exp); end
        end
        a_rd_en = 1'b0;
        total++; if (a_empty !== 1'b1) begin bad++; $display("[TB] FAIL final_empty got=%b want=1", a_empty); end
    endtask

    // DEPTH=5: 23 words through with reads on 3 of every 5 cycles.
    task automatic test_wrap();
        int wcnt = 0, rcnt = 0, mcnt = 0;
        logic do_wr, do_rd;
        logic [7:0] exp;
        logic [7:0] bq [$];
        for (int cyc = 0; cyc < 300 && rcnt < 23; cyc++) begin
            do_wr = (wcnt < 23) && (mcnt < 5);
            do_rd = ((cyc % 5) < 3) && (mcnt > 0);
            b_wr_en = do_wr; b_rd_en = do_rd; b_wr_data = 8'(8'h40 + wcnt);
            tick();
            if (do_wr) begin bq.push_back(8'(8'h40 + wcnt)); wcnt++; mcnt++; end
            if (do_rd) begin
                exp = bq.pop_front(); rcnt++; mcnt--;
                total++; if (b_rd_valid !== 1'b1 || b_rd_data !== exp) begin bad++; $display("[TB] FAIL wrap_data idx=%0d got=%b/%h want=1/%h", rcnt - 1, b_rd_valid, b_rd_data, exp); end
            end
            total++; if (b_count !== 3'(mcnt)) begin bad++; $display("[TB] FAIL wrap_count cyc=%0d got=%0d want=%0d", cyc, b_count, mcnt); end
        end
        b_wr_en = 1'b0; b_rd_en = 1'b0;
        total++; if (rcnt != 23 || b_empty !== 1'b1) begin bad++; $display("[TB] FAIL wrap_done got=%0d/%b want=23/1", rcnt, b_empty); end
    endtask

    task automatic test_fwft_reset();
        f_wr_en = 1'b1; f_wr_data = 8'h5A;
        tick();
        f_wr_en = 1'b0;
        total++; if (f_rd_valid !== 1'b1 || f_rd_data !== 8'h5A) begin bad++; $display("[TB] FAIL fwft_first got=%b/%h want=1/5a", f_rd_valid, f_rd_data); end
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        total++; if (f_rd_valid !== 1'b0 || f_empty !== 1'b1) begin bad++; $display("[TB] FAIL fwft_pop_empty got=%b/%b want=0/1", f_rd_valid, f_empty); end
        for (int i = 0; i < 7; i++) begin
            f_wr_en = 1'b1; f_wr_data = 8'(8'h60 + i);
            tick();
        end
        f_wr_en = 1'b0;
        total++; if (f_count !== 5'd7 || f_rd_data !== 8'h60) begin bad++; $display("[TB] FAIL fwft_load got=%0d/%h want=7/60", f_count, f_rd_data); end
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        total++; if (f_rd_data !== 8'h61 || f_count !== 5'd6) begin bad++; $display("[TB] FAIL fwft_next got=%h/%0d want=61/6", f_rd_data, f_count); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++; if (f_count !== 5'd0 || f_empty !== 1'b1 || f_rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL fwft_midreset got=%0d/%b/%b want=0/1/0", f_count, f_empty, f_rd_valid); end
        f_wr_en = 1'b1; f_wr_data = 8'h77;
        tick();
        f_wr_en = 1'b0;
        total++; if (f_rd_data !== 8'h77 || f_count !== 5'd1 || f_rd_valid !== 1'b1) begin bad++; $display("[TB] FAIL fwft_post_reset got=%h/%0d/%b want=77/1/1", f_rd_data, f_count, f_rd_valid); end
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        total++; if (f_empty !== 1'b1) begin bad++; $display("[TB] FAIL fwft_final_empty got=%b want=1", f_empty); end
    endtask

    initial begin
        test_reset();
        test_fill_thresholds();
        test_overflow();
        test_drain();
        test_underflow();
        test_simultaneous();
        test_wrap();
        test_fwft_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hang in any scenario.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule
